// File: rtl/systolic_ctrl_if.sv
// rtl/systolic_ctrl_if.sv - host command and operand-feed signals of the systolic array sequencer
interface systolic_ctrl_if #(
    parameter int N  = 3,
    parameter int KW = 8
);
    logic              start;
    logic [KW-1:0]     k_len;
    logic              busy;
    logic              done;
    logic              pe_clr;
    logic [N-1:0]      a_valid;
    logic [N*KW-1:0]   a_addr;
    logic [N-1:0]      w_valid;
    logic [N*KW-1:0]   w_addr;
    logic              cap;

    modport master (
        input  start, k_len,
        output busy, done, pe_clr, a_valid, a_addr, w_valid, w_addr, cap
    );

    modport slave (
        output start, k_len,
        input  busy, done, pe_clr, a_valid, a_addr, w_valid, w_addr, cap
    );
endinterface

// File: rtl/systolic_ctrl.sv
// rtl/systolic_ctrl.sv - job sequencer: clear, skewed operand feed, drain, capture, done
module systolic_ctrl #(
    parameter int N  = 3,
    parameter int KW = 8
) (
    input  logic clk,
    input  logic rst,
    systolic_ctrl_if.master bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLEAR   = 3'd1;
    localparam logic [2:0] S_FEED    = 3'd2;
    localparam logic [2:0] S_DRAIN   = 3'd3;
    localparam logic [2:0] S_CAPTURE = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic [KW+1:0] NM1    = (KW+2)'(N - 1);
    localparam logic [KW:0]   DR_END = (KW+1)'(N - 1);

    logic [2:0]      state, state_n;
    logic [KW-1:0]   k_r, k_n;
    logic [KW:0]     t, t_n;
    logic [KW:0]     dcnt, dcnt_n;

    logic            busy_r, done_r, clr_r, cap_r;
    logic [N-1:0]    valid_r, valid_n;
    logic [N*KW-1:0] addr_r, addr_n;
    logic [KW:0]     lane_off;

    always_comb begin
        state_n = state;
        k_n     = k_r;
        t_n     = t;
        dcnt_n  = dcnt;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    k_n     = bus.k_len;
                    t_n     = '0;
                    state_n = S_CLEAR;
                end
            end
            S_CLEAR: begin
                t_n     = '0;
                state_n = (k_r == '0) ? S_CAPTURE : S_FEED;
            end
            S_FEED: begin
                // last feed cycle is t == k_r + N - 2
                if (({1'b0, t} + 1'b1) == ({2'b00, k_r} + NM1)) begin
                    dcnt_n  = '0;
                    state_n = S_DRAIN;
                end else begin
                    t_n = t + 1'b1;
                end
            end
            S_DRAIN: begin
                if (dcnt == DR_END) state_n = S_CAPTURE;
                else                dcnt_n  = dcnt + 1'b1;
            end
            S_CAPTURE: state_n = S_DONE;
            S_DONE:    state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    // Outputs are decoded from the state being entered so they appear registered.
    always_comb begin
        valid_n  = '0;
        addr_n   = '0;
        lane_off = '0;
        if (state_n == S_FEED) begin
            for (int i = 0; i < N; i++) begin
                if (({1'b0, t_n} >= (KW+2)'(i)) &&
                    ({1'b0, t_n} < ((KW+2)'(i) + {2'b00, k_n}))) begin
                    valid_n[i]           = 1'b1;
                    lane_off             = t_n - (KW+1)'(i);
                    addr_n[i*KW +: KW]   = lane_off[KW-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            k_r     <= '0;
            t       <= '0;
            dcnt    <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            clr_r   <= 1'b0;
            cap_r   <= 1'b0;
            valid_r <= '0;
            addr_r  <= '0;
        end else begin
            state   <= state_n;
            k_r     <= k_n;
            t       <= t_n;
            dcnt    <= dcnt_n;
            busy_r  <= (state_n != S_IDLE);
            done_r  <= (state_n == S_DONE);
            clr_r   <= (state_n == S_CLEAR);
            cap_r   <= (state_n == S_CAPTURE);
            valid_r <= valid_n;
            addr_r  <= addr_n;
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.pe_clr  = clr_r;
    assign bus.cap     = cap_r;
    assign bus.a_valid = valid_r;
    assign bus.w_valid = valid_r;
    assign bus.a_addr  = addr_r;
    assign bus.w_addr  = addr_r;
endmodule

// File: tb/tb_systolic_ctrl.sv
// tb/tb_systolic_ctrl.sv - directed and randomized job sequences checked against a cycle model
module tb_systolic_ctrl;
    localparam int N  = 3;
    localparam int KW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    systolic_ctrl_if #(.N(N), .KW(KW)) bus ();

    systolic_ctrl #(.N(N), .KW(KW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(string tag, logic [N*KW-1:0] obs, logic [N*KW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected outputs j cycles after the accepting edge of a job of length k;
    // j=0 or j past the job means idle (all zero).
    task automatic check_cycle(string tag, int j, int k);
        int lat;
        logic e_busy, e_done, e_clr, e_cap;
        logic [N-1:0] e_val;
        logic [N*KW-1:0] e_addr;
        int tt;
        lat    = (k == 0) ? 3 : k + 2*N + 2;
        e_busy = (j >= 1) && (j <= lat);
        e_clr  = (j == 1);
        e_cap  = (j == lat - 1) && (j >= 1);
        e_done = (j == lat) && (j >= 1);
        e_val  = '0;
        e_addr = '0;
        if (k > 0 && j >= 2 && j <= k + N) begin
            tt = j - 2;
            for (int i = 0; i < N; i++) begin
                if (tt >= i && tt < i + k) begin
                    e_val[i] = 1'b1;
                    e_addr[i*KW +: KW] = KW'(tt - i);
                end
            end
        end
        cmp({tag, ".busy"},    N*KW'(bus.busy),    N*KW'(e_busy));
        cmp({tag, ".done"},    N*KW'(bus.done),    N*KW'(e_done));
        cmp({tag, ".pe_clr"},  N*KW'(bus.pe_clr),  N*KW'(e_clr));
        cmp({tag, ".cap"},     N*KW'(bus.cap),     N*KW'(e_cap));
        cmp({tag, ".a_valid"}, N*KW'(bus.a_valid), N*KW'(e_val));
        cmp({tag, ".w_valid"}, N*KW'(bus.w_valid), N*KW'(e_val));
        cmp({tag, ".a_addr"},  bus.a_addr,         e_addr);
        cmp({tag, ".w_addr"},  bus.w_addr,         e_addr);
    endtask

    // Called at #1 into an idle cycle; that cycle becomes cycle 0 of the job.
    task automatic run_job(string tag, int k, bit hold, int pulse_at, int rst_at);
        int lat;
        lat = (k == 0) ? 3 : k + 2*N + 2;
        bus.start = 1'b1;
        bus.k_len = KW'(k);
        step();
        for (int j = 1; j <= lat + 1; j++) begin
            if (!hold) bus.start = 1'b0;
            if (j == pulse_at + 1) bus.k_len = KW'(2);
            check_cycle($sformatf("%s.c%0d", tag, j), j, k);
            if (j == pulse_at) begin
                bus.start = 1'b1;
                bus.k_len = KW'(7);
            end
            if (j == rst_at) begin
                rst = 1'b0;
                step();
                check_cycle($sformatf("%s.rst", tag), 0, k);
                rst = 1'b1;
                bus.start = 1'b0;
                step();
                check_cycle($sformatf("%s.post_rst", tag), 0, k);
                return;
            end
            if (j <= lat) step();
        end
    endtask

    initial begin
        int k;
        int gap;
        bus.start = 1'b1;
        bus.k_len = KW'(5);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            check_cycle($sformatf("reset%0d", c), 0, 0);
        end
        rst = 1'b1;
        bus.start = 1'b0;
        step();
        check_cycle("released", 0, 0);

        run_job("nominal", 4, 1'b0, -1, -1);
        run_job("zero", 0, 1'b0, -1, -1);
        run_job("busyrej", 4, 1'b0, 5, -1);
        run_job("midrst", 4, 1'b0, -1, 6);
        run_job("after_rst", 4, 1'b0, -1, -1);

        run_job("b2b_a", 1, 1'b1, -1, -1);
        run_job("b2b_b", 1, 1'b1, -1, -1);
        bus.start = 1'b0;
        step();
        check_cycle("b2b_idle", 0, 0);

        run_job("kmax", 255, 1'b0, -1, -1);

        for (int r = 0; r < 10; r++) begin
            k = int'($urandom_range(0, 12));
            run_job($sformatf("rnd%0d_k%0d", r, k), k, 1'b0, -1, -1);
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                bus.k_len = KW'($urandom);
                step();
                check_cycle($sformatf("rnd%0d_gap", r), 0, 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
